if_fetch: RTL and testbench

Instruction-fetch stage for the 16-bit five-stage pipeline. It owns the program counter and the IF/ID pipeline register, and feeds the decode stage, whose outputs are in turn latched into the ID/EXE register. It stalls on load-use hazards and on instruction-RAM conflicts with the MEM stage, flushes on taken branches or jumps, and buffers one redirect that arrives while the stage is stalled.

---
 rtl/if_fetch.sv | 97 +++++++++
 tb/tb_if_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and the IF/ID register.
// It also buffers one redirect that arrives while the stage is stalled.
module if_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifKeep,
  input  logic        ifClear,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        memConflict,
  input  logic [15:0] instr_in,
  output logic [15:0] pc_out,
  output logic        fetch_en,
  output logic [15:0] instr_out,
  output logic [15:0] pc_next_out,
  output logic        valid_out,
  output logic        redirect_pending
);

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] instr;
    logic [W-1:0] pc_next;
    logic         valid;
  } ifid_t;

  localparam ifid_t BUBBLE = {NOP_INSTR, 16'h0000, 1'b0};

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic         pend_q, pend_d;
  logic         pend_apply;
  ifid_t        ifid_q, ifid_d;

  // Next-state: PC/redirect buffer first, then IF/ID using the same decision.
  always_comb begin
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    pend_d     = pend_q;
    ifid_d     = ifid_q;
    pend_apply = 1'b0;

    if (jump_en && !ifKeep) begin
      pc_d   = jump_target;
      pend_d = 1'b0;
    end else if (jump_en) begin
      pend_d = 1'b1;
      tgt_d  = jump_target;
    end else if (pend_q && !ifKeep) begin
      pc_d       = tgt_q;
      pend_d     = 1'b0;
      pend_apply = 1'b1;
    end else if (!ifKeep && !memConflict) begin
      pc_d = pc_q + W'(1);
    end

    // A flush wins over a stall; otherwise a stall freezes IF/ID entirely.
    if (ifClear) begin
      ifid_d = BUBBLE;
    end else if (!ifKeep) begin
      if (jump_en || pend_apply || memConflict) begin
        ifid_d = BUBBLE;
      end else begin
        ifid_d.instr   = instr_in;
        ifid_d.pc_next = pc_q + W'(1);
        ifid_d.valid   = 1'b1;
      end
    end
  end

  // Pipeline registers update on the falling edge like the other stages.
  always_ff @(negedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
      tgt_q  <= '0;
      ifid_q <= BUBBLE;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
      ifid_q <= ifid_d;
    end
  end

  assign fetch_en         = !ifKeep && !memConflict;
  assign pc_out           = pc_q;
  assign instr_out        = ifid_q.instr;
  assign pc_next_out      = ifid_q.pc_next;
  assign valid_out        = ifid_q.valid;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic.
// The driver predicts each edge's outputs into a queue and the monitor checks them on rising edges.
module tb_if_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifKeep = 1'b0, ifClear = 1'b0, jump_en = 1'b0, memConflict = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] instr_in;
  logic [15:0] pc_out, instr_out, pc_next_out;
  logic        fetch_en, valid_out, redirect_pending;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcn;
    logic        valid;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   started = 1'b0;

  // Reference state, advanced once per falling edge by the driver.
  logic [15:0] m_pc, m_tgt, m_instr, m_pcn;
  logic        m_pend, m_valid;

  if_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .ifKeep(ifKeep), .ifClear(ifClear),
    .jump_en(jump_en), .jump_target(jump_target), .memConflict(memConflict),
    .instr_in(instr_in), .pc_out(pc_out), .fetch_en(fetch_en),
    .instr_out(instr_out), .pc_next_out(pc_next_out), .valid_out(valid_out),
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  assign instr_in = instr_of(pc_out);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs and predict the state after the next falling edge.
  task automatic step(input logic r, input logic k, input logic c, input logic j,
                      input logic [15:0] jt, input logic m);
    logic [15:0] n_pc, n_tgt, fetched;
    logic        n_pend, redirected, stall, bubble;
    @(posedge clk);
    #1;
    rst = r; ifKeep = k; ifClear = c; jump_en = j; jump_target = jt; memConflict = m;
    started = 1'b1;
    fetched    = instr_of(m_pc);
    stall      = k;
    redirected = 1'b0;
    n_pc = m_pc; n_tgt = m_tgt; n_pend = m_pend;
    if (j) begin
      if (stall) begin n_pend = 1'b1; n_tgt = jt; end
      else begin n_pc = jt; n_pend = 1'b0; end
    end else if (m_pend && !stall) begin
      n_pc = m_tgt; n_pend = 1'b0; redirected = 1'b1;
    end else if (!stall && !m) begin
      n_pc = m_pc + 16'd1;
    end
    bubble = c || (!stall && (j || redirected || m));
    if (!r) begin
      m_pc = RST_PC; m_pend = 1'b0; m_tgt = n_tgt;
      m_instr = NOP; m_pcn = 16'h0000; m_valid = 1'b0;
    end else begin
      if (bubble) begin
        m_instr = NOP; m_pcn = 16'h0000; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = fetched; m_pcn = m_pc + 16'd1; m_valid = 1'b1;
      end
      m_pc = n_pc; m_pend = n_pend; m_tgt = n_tgt;
    end
    exp_q.push_back('{pc: m_pc, instr: m_instr, pcn: m_pcn, valid: m_valid, pend: m_pend});
  endtask

  // Monitor: outputs settle on the falling edge, so check them on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (started) chk("fetch_en", {15'd0, fetch_en}, {15'd0, (!ifKeep && !memConflict)});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("instr_out", instr_out, e.instr);
        chk("pc_next_out", pc_next_out, e.pcn);
        chk("valid_out", {15'd0, valid_out}, {15'd0, e.valid});
        chk("redirect_pending", {15'd0, redirect_pending}, {15'd0, e.pend});
      end
    end
  end

  initial begin
    int budget;
    logic k, c, j, m, r;
    // Reset, then free-run.
    step(0, 0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 0, 16'h0, 0);
    repeat (4) step(1, 0, 0, 0, 16'h0, 0);
    // Wrap at 16'hFFFF.
    step(1, 0, 0, 1, 16'hFFFF, 0);
    repeat (2) step(1, 0, 0, 0, 16'h0, 0);
    // Two-cycle memConflict at pc=5.
    step(1, 0, 0, 1, 16'h0005, 0);
    repeat (2) step(1, 0, 0, 0, 16'h0, 1);
    repeat (2) step(1, 0, 0, 0, 16'h0, 0);
    // Redirect buffered during a three-cycle stall.
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 1, 0, 1, 16'h0040, 0);
    step(1, 1, 0, 0, 16'h0, 0);
    repeat (3) step(1, 0, 0, 0, 16'h0, 0);
    // Flush while stalled.
    step(1, 1, 1, 0, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    // Pending target overridden by a jump on the release edge.
    step(1, 1, 0, 1, 16'h0010, 0);
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 1, 16'h0020, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    // Reset with a redirect pending.
    step(1, 1, 0, 1, 16'h0030, 0);
    step(0, 1, 0, 0, 16'h0, 0);
    repeat (2) step(1, 0, 0, 0, 16'h0, 0);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) != 0);
      k = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 7) == 0);
      m = ($urandom_range(0, 4) == 0);
      step(r, k, c, j, 16'($urandom_range(0, 65535)), m);
    end
    step(1, 0, 0, 0, 16'h0, 0);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
